divide_unit: RTL and testbench

Iterative restoring integer divider for the execution stage. It is the inverse counterpart of the ALU's shift-and-add datapath. It performs one quotient bit per clock using the existing AdderUnit as the trial subtractor, and supports signed and unsigned operands. A start/busy/done handshake lets the pipeline stall on DIV/REM instructions while the ALU handles all single-cycle operations.

---
 rtl/divide_unit_pkg.sv | 11 +
 rtl/divide_unit_adder.sv | 20 ++
 rtl/divide_unit.sv | 138 +++++++++++++
 tb/tb_divide_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divide_unit_pkg.sv
// Shared constants for the iterative divider.
// Word length and the 2-bit FSM state encodings.
package divide_unit_pkg;

  localparam int WORD_LENGTH = 32;

  localparam logic [1:0] DIV_ST_IDLE = 2'd0;
  localparam logic [1:0] DIV_ST_RUN  = 2'd1;
  localparam logic [1:0] DIV_ST_FIX  = 2'd2;

endpackage

// File: rtl/divide_unit_adder.sv
// AdderUnit: WIDTH-bit ripple adder with carry in/out.
// Ports: a, b, inC -> sum, outC. Bit 0 is the MSB.
module AdderUnit #(
  parameter int WIDTH = 33
) (
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  input  logic             inC,
  output logic [0:WIDTH-1] sum,
  output logic             outC
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, inC};
  assign outC = full[WIDTH];
  assign sum  = full[WIDTH-1:0];

endmodule

// File: rtl/divide_unit.sv
// divide_unit: restoring signed/unsigned divider, one bit per clock.
// Ports: clk, rst, start, isSigned, a, b -> busy, done, q, r, divZero, ovf.
import divide_unit_pkg::*;

module divide_unit #(
  parameter int WIDTH = WORD_LENGTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             isSigned,
  input  logic [0:WIDTH-1] a,
  input  logic [0:WIDTH-1] b,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] q,
  output logic [0:WIDTH-1] r,
  output logic             divZero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:WIDTH-1] MIN_VAL =
    {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [0:WIDTH-1] cneg(
    input logic [0:WIDTH-1] v,
    input logic             en
  );
    logic [0:WIDTH-1] one;
    one            = '0;
    one[WIDTH-1]   = 1'b1;
    return en ? (~v) + one : v;
  endfunction

  logic [1:0]       state;
  logic [0:WIDTH-1] dvd;
  logic [0:WIDTH-1] dsr;
  logic [0:WIDTH-1] rem;
  logic [0:WIDTH-1] quo;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             dz_p;
  logic             ov_p;

  logic [0:WIDTH] trial_a;
  logic [0:WIDTH] trial_b;
  logic [0:WIDTH] trial_d;
  logic           trial_c;
  logic           take;

  assign trial_a = {rem, dvd[0]};
  assign trial_b = ~{1'b0, dsr};

  AdderUnit #(.WIDTH(WIDTH + 1)) u_sub (
    .a    (trial_a),
    .b    (trial_b),
    .inC  (1'b1),
    .sum  (trial_d),
    .outC (trial_c)
  );

  // No borrow means the difference is below the divisor,
  // so its top bit is always clear.
  assign take = trial_c & ~trial_d[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
      divZero <= 1'b0;
      ovf     <= 1'b0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_p    <= 1'b0;
      ov_p    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        DIV_ST_IDLE: begin
          if (start) begin
            if (b == '0) begin
              // Result is staged directly: q = ~0, r = a.
              dz_p  <= 1'b1;
              ov_p  <= 1'b0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              quo   <= '1;
              rem   <= a;
              state <= DIV_ST_FIX;
            end else begin
              dz_p  <= 1'b0;
              ov_p  <= isSigned && (a == MIN_VAL)
                       && (b == '1);
              neg_q <= isSigned & (a[0] ^ b[0]);
              neg_r <= isSigned & a[0];
              dvd   <= cneg(a, isSigned & a[0]);
              dsr   <= cneg(b, isSigned & b[0]);
              rem   <= '0;
              quo   <= '0;
              cnt   <= CW'(WIDTH - 1);
              busy  <= 1'b1;
              state <= DIV_ST_RUN;
            end
          end
        end
        DIV_ST_RUN: begin
          rem <= take ? trial_d[1:WIDTH]
                      : trial_a[1:WIDTH];
          quo <= {quo[1:WIDTH-1], take};
          dvd <= {dvd[1:WIDTH-1], 1'b0};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= DIV_ST_FIX;
        end
        DIV_ST_FIX: begin
          q       <= cneg(quo, neg_q);
          r       <= cneg(rem, neg_r);
          divZero <= dz_p;
          ovf     <= ov_p;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= DIV_ST_IDLE;
        end
        default: state <= DIV_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Directed-vector bench for divide_unit.
// Each task drives one scenario and checks results inline.
module tb_divide_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        isSigned;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        divZero;
  logic        ovf;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  divide_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .isSigned (isSigned),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .divZero  (divZero),
    .ovf      (ovf)
  );

  // Issues one start edge, then counts edges until done.
  task automatic run_div(
    input  logic [31:0] aa,
    input  logic [31:0] bb,
    input  logic        sg,
    output int          lat,
    output logic        busy_ok
  );
    a = aa;
    b = bb;
    isSigned = sg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    isSigned = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, divZero, ovf} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, done, divZero, ovf});
    end
    n_vec++;
    if ({q, r} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_qr got %h/%h want 0/0", q, r);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    int   lat;
    logic bok;
    run_div(32'd100, 32'd7, 1'b0, lat, bok);
    n_vec++;
    if (lat !== 33) begin
      n_bad++;
      $display("FAIL u_latency got %0d want 33", lat);
    end
    n_vec++;
    if (bok !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL u_busy got ok=%b end=%b want 1/0",
               bok, busy);
    end
    n_vec++;
    if (q !== 32'd14 || r !== 32'd2) begin
      n_bad++;
      $display("FAIL u_100_7 got %0d/%0d want 14/2", q, r);
    end
    n_vec++;
    if ({divZero, ovf} !== 2'b00) begin
      n_bad++;
      $display("FAIL u_flags got %b want 00",
               {divZero, ovf});
    end
  endtask

  task automatic test_signed;
    int   lat;
    logic bok;
    run_div(32'hFFFFFF9C, 32'd7, 1'b1, lat, bok);
    n_vec++;
    if (q !== 32'hFFFFFFF2 || r !== 32'hFFFFFFFE) begin
      n_bad++;
      $display("FAIL s_m100_7 got %h/%h want fffffff2/fffffffe",
               q, r);
    end
    run_div(32'd100, 32'hFFFFFFF9, 1'b1, lat, bok);
    n_vec++;
    if (q !== 32'hFFFFFFF2 || r !== 32'd2) begin
      n_bad++;
      $display("FAIL s_100_m7 got %h/%h want fffffff2/2",
               q, r);
    end
    n_vec++;
    if (lat !== 33 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL s_lat_ovf got %0d/%b want 33/0",
               lat, ovf);
    end
  endtask

  task automatic test_overflow;
    int   lat;
    logic bok;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, bok);
    n_vec++;
    if (q !== 32'h80000000 || r !== 32'h0 || ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_signed got %h/%h/%b want 80000000/0/1",
               q, r, ovf);
    end
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, bok);
    n_vec++;
    if (q !== 32'h0 || r !== 32'h80000000 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_unsigned got %h/%h/%b want 0/80000000/0",
               q, r, ovf);
    end
  endtask

  task automatic test_div_zero;
    int   lat;
    logic bok;
    for (int m = 0; m < 2; m++) begin
      run_div(32'd5, 32'd0, m[0], lat, bok);
      n_vec++;
      if (lat !== 1) begin
        n_bad++;
        $display("FAIL dz_latency mode%0d got %0d want 1",
                 m, lat);
      end
      n_vec++;
      if (q !== 32'hFFFFFFFF || r !== 32'd5
          || divZero !== 1'b1 || ovf !== 1'b0) begin
        n_bad++;
        $display("FAIL dz_result mode%0d got %h/%h/%b%b want ffffffff/5/10",
                 m, q, r, divZero, ovf);
      end
    end
    run_div(32'd10, 32'd3, 1'b0, lat, bok);
    n_vec++;
    if (q !== 32'd3 || r !== 32'd1 || divZero !== 1'b0) begin
      n_bad++;
      $display("FAIL dz_clear got %0d/%0d/%b want 3/1/0",
               q, r, divZero);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    a = 32'd100;
    b = 32'd7;
    isSigned = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      if (i == 6) begin
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat !== 33 || q !== 32'd14 || r !== 32'd2) begin
      n_bad++;
      $display("FAIL ignore_start got lat=%0d %0d/%0d want 33 14/2",
               lat, q, r);
    end
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept got done=%b busy=%b want 0/1",
               done, busy);
    end
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat !== 33 || q !== 32'd3 || r !== 32'd0) begin
      n_bad++;
      $display("FAIL b2b_result got lat=%0d %0d/%0d want 33 3/0",
               lat, q, r);
    end
  endtask

  task automatic test_reset_mid;
    int   lat;
    logic bok;
    logic seen;
    a = 32'd100;
    b = 32'd7;
    isSigned = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || q !== 32'h0 || r !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid got busy=%b %h/%h want 0 0/0",
               busy, q, r);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_done got %b want 0", seen);
    end
    run_div(32'hFFFFFFFF, 32'h10, 1'b0, lat, bok);
    n_vec++;
    if (q !== 32'h0FFFFFFF || r !== 32'hF || lat !== 33) begin
      n_bad++;
      $display("FAIL rst_after got %h/%h lat=%0d want 0fffffff/f 33",
               q, r, lat);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
